fpu_result_stage: RTL and testbench

- Output stage of the FP add/sub datapath. Sits directly downstream of the exception-detection stage.
- Takes the packed result fields and the five raw exception flags from that stage.
- Forces IEEE special encodings where a flag requires it, and buffers results in a small valid/ready FIFO.
- Keeps a sticky exception-flag register with software clear and a masked interrupt.

---
 rtl/fpu_result_stage.sv | 140 ++++++++++++++
 tb/tb_fpu_result_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_result_stage.sv
// Output stage of the FP add/sub datapath: special-encoding packer, result FIFO and sticky flag/IRQ logic.
// Optional flush-to-zero of subnormal results is enabled by defining FPU_FTZ_EN.
`timescale 1ns/1ps
module fpu_result_stage #(
    parameter int unsigned DEPTH        = 2,
    parameter logic [31:0] QNAN_PATTERN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign_z,
    input  logic [7:0]  exponent_z,
    input  logic [22:0] mantissa_z,
    input  logic        invalid_flag,
    input  logic        overflow_flag,
    input  logic        underflow_flag,
    input  logic        inexact_flag,
    input  logic        zero_flag,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags,
    input  logic        clear_sticky,
    input  logic [4:0]  irq_mask,
    output logic [4:0]  sticky_flags,
    output logic        flag_irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] word;
        logic [4:0]  flags;
    } entry_t;

    // Flag vector order is {invalid, overflow, underflow, inexact, zero}.
    function automatic entry_t pack_entry(input logic        s,
                                          input logic [7:0]  e,
                                          input logic [22:0] m,
                                          input logic [4:0]  f);
        entry_t r;
        r.flags = f;
        if (f[4]) begin
            r.word = QNAN_PATTERN;
        end else if (f[3]) begin
            r.word = {s, 8'hFF, 23'h0};
        end else if (f[0]) begin
            r.word = {s, 31'h0};
`ifdef FPU_FTZ_EN
        end else if (f[2] || (e == 8'h00 && m != 23'h0)) begin
            r.word     = {s, 31'h0};
            r.flags[1] = 1'b1;
            r.flags[0] = 1'b1;
`endif
        end else begin
            r.word = {s, e, m};
        end
        return r;
    endfunction

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [4:0]       out_flags_q, out_flags_d;
    logic [4:0]       sticky_q, sticky_d;
    logic             irq_q, irq_d;
    entry_t           entry_in;
    entry_t           head_d;
    logic             accept;
    logic             pop;

    assign in_ready     = (count_q != FULL_CNT);
    assign out_valid    = (count_q != '0);
    assign out_result   = out_result_q;
    assign out_flags    = out_flags_q;
    assign sticky_flags = sticky_q;
    assign flag_irq     = irq_q;

    always_comb begin
        entry_in = pack_entry(sign_z, exponent_z, mantissa_z,
                              {invalid_flag, overflow_flag, underflow_flag,
                               inexact_flag, zero_flag});
        accept   = in_valid & in_ready;
        pop      = out_valid & out_ready;

        wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The new head is the incoming word only when it lands in an otherwise empty buffer.
        head_d = (accept && (rd_ptr_d == wr_ptr_q)) ? entry_in : mem_q[rd_ptr_d];

        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (count_d != '0) begin
            out_result_d = head_d.word;
            out_flags_d  = head_d.flags;
        end

        sticky_d = (clear_sticky ? 5'b0 : sticky_q) | (accept ? entry_in.flags : 5'b0);
        irq_d    = |(sticky_q & irq_mask);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= entry_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_result_q <= '0;
            out_flags_q  <= '0;
            sticky_q     <= '0;
            irq_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            sticky_q     <= sticky_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_fpu_result_stage.sv
// Self-checking bench for fpu_result_stage: vector table, hand sequences and a queue-based reference model.
`timescale 1ns/1ps
module tb_fpu_result_stage;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
`ifdef FPU_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_z = 1'b0;
    logic [7:0]  exponent_z = '0;
    logic [22:0] mantissa_z = '0;
    logic        invalid_flag = 1'b0, overflow_flag = 1'b0, underflow_flag = 1'b0;
    logic        inexact_flag = 1'b0, zero_flag = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic        clear_sticky = 1'b0;
    logic [4:0]  irq_mask = '0;
    logic [4:0]  sticky_flags;
    logic        flag_irq;

    always #5 clk = ~clk;

    fpu_result_stage #(.DEPTH(DEPTH), .QNAN_PATTERN(QNAN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_z(sign_z), .exponent_z(exponent_z), .mantissa_z(mantissa_z),
        .invalid_flag(invalid_flag), .overflow_flag(overflow_flag),
        .underflow_flag(underflow_flag), .inexact_flag(inexact_flag), .zero_flag(zero_flag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .clear_sticky(clear_sticky), .irq_mask(irq_mask),
        .sticky_flags(sticky_flags), .flag_irq(flag_irq)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                         input logic [4:0] f);
        in_valid   = 1'b1;
        sign_z     = s;
        exponent_z = e;
        mantissa_z = m;
        {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag} = f;
    endtask

    // Reference model: a queue of {word, flags} plus sticky/irq state.
    typedef struct packed {
        logic [31:0] w;
        logic [4:0]  f;
    } ent_t;

    function automatic ent_t ref_pack(input logic s, input logic [7:0] e,
                                      input logic [22:0] m, input logic [4:0] f);
        ent_t r;
        r.f = f;
        if (f[4])      r.w = QNAN;
        else if (f[3]) r.w = {s, 8'hFF, 23'h0};
        else if (f[0]) r.w = {s, 31'h0};
        else if (FTZ && (f[2] || (e == 8'd0 && m != 23'd0))) begin
            r.w = {s, 31'h0};
            r.f = f | 5'b00011;
        end else       r.w = {s, e, m};
        return r;
    endfunction

    ent_t        mq[$];
    logic [4:0]  m_sticky = '0;
    logic        m_irq    = 1'b0;
    logic [31:0] m_w      = '0;
    logic [4:0]  m_f      = '0;

    always @(negedge clk) begin : model
        ent_t       e;
        bit         acc, pop;
        logic [4:0] nst;
        if (!rst_n) begin
            mq.delete();
            m_sticky = '0;
            m_irq    = 1'b0;
            m_w      = '0;
            m_f      = '0;
        end
        chk("mdl_in_ready",  32'(in_ready),     32'(mq.size() < int'(DEPTH)));
        chk("mdl_out_valid", 32'(out_valid),    32'(mq.size() > 0));
        chk("mdl_result",    out_result,        m_w);
        chk("mdl_flags",     32'(out_flags),    32'(m_f));
        chk("mdl_sticky",    32'(sticky_flags), 32'(m_sticky));
        chk("mdl_irq",       32'(flag_irq),     32'(m_irq));
        if (rst_n) begin
            acc = in_valid && (mq.size() < int'(DEPTH));
            pop = (mq.size() > 0) && out_ready;
            e   = ref_pack(sign_z, exponent_z, mantissa_z,
                           {invalid_flag, overflow_flag, underflow_flag, inexact_flag, zero_flag});
            nst = (clear_sticky ? 5'b0 : m_sticky) | (acc ? e.f : 5'b0);
            m_irq    = |(m_sticky & irq_mask);
            m_sticky = nst;
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
            if (mq.size() > 0) begin
                m_w = mq[0].w;
                m_f = mq[0].f;
            end
        end
    end

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [4:0]  f;
        logic [31:0] xw;
        logic [4:0]  xf;
    } vec_t;

    vec_t vt[11];

    initial begin
        vt[0]  = '{1'b0, 8'h80, 23'h400000, 5'b00000, 32'h40400000, 5'b00000};
        vt[1]  = '{1'b0, 8'h12, 23'h000005, 5'b11000, 32'h7FC00000, 5'b11000};
        vt[2]  = '{1'b1, 8'hFE, 23'h7FFFFF, 5'b01010, 32'hFF800000, 5'b01010};
        vt[3]  = '{1'b1, 8'h00, 23'h000000, 5'b00001, 32'h80000000, 5'b00001};
        vt[4]  = '{1'b0, 8'h55, 23'h123456, 5'b00011, 32'h00000000, 5'b00011};
`ifdef FPU_FTZ_EN
        vt[5]  = '{1'b1, 8'h00, 23'h000001, 5'b00100, 32'h80000000, 5'b00111};
        vt[6]  = '{1'b0, 8'h00, 23'h7FFFFF, 5'b00010, 32'h00000000, 5'b00011};
`else
        vt[5]  = '{1'b1, 8'h00, 23'h000001, 5'b00100, 32'h80000001, 5'b00100};
        vt[6]  = '{1'b0, 8'h00, 23'h7FFFFF, 5'b00010, 32'h007FFFFF, 5'b00010};
`endif
        vt[7]  = '{1'b1, 8'h7F, 23'h000000, 5'b00010, 32'hBF800000, 5'b00010};
        vt[8]  = '{1'b0, 8'h33, 23'h000777, 5'b10001, 32'h7FC00000, 5'b10001};
        vt[9]  = '{1'b0, 8'h10, 23'h000001, 5'b01001, 32'h7F800000, 5'b01001};
        vt[10] = '{1'b1, 8'h00, 23'h000000, 5'b00101, 32'h80000000, 5'b00101};

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    out_result,     32'd0);
        chk("rst_flags",     32'(out_flags), 32'd0);
        chk("rst_sticky",    32'(sticky_flags), 32'd0);
        chk("rst_irq",       32'(flag_irq),  32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Packing table; each accept also clears sticky so sticky equals the stored flags
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].s, vt[i].e, vt[i].m, vt[i].f);
            clear_sticky = 1'b1;
            out_ready    = 1'b1;
            step();
            in_valid     = 1'b0;
            clear_sticky = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i),  32'(out_valid),    32'd1);
            chk($sformatf("vec%0d_result", i), out_result,        vt[i].xw);
            chk($sformatf("vec%0d_flags", i),  32'(out_flags),    32'(vt[i].xf));
            chk($sformatf("vec%0d_sticky", i), 32'(sticky_flags), 32'(vt[i].xf));
            step();
        end

        // Interrupt timing and masking
        clear_sticky = 1'b1;
        irq_mask     = 5'b10000;
        step();
        clear_sticky = 1'b0;
        drive(1'b0, 8'h12, 23'h5, 5'b11000);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("irq_sticky", 32'(sticky_flags), 32'h18);
        chk("irq_early",  32'(flag_irq),     32'd0);
        chk("irq_qnan",   out_result,        QNAN);
        step();
        @(negedge clk);
        chk("irq_set", 32'(flag_irq), 32'd1);
        step();
        irq_mask = 5'b00100;
        step();
        @(negedge clk);
        chk("irq_masked", 32'(flag_irq), 32'd0);
        step();
        irq_mask = 5'b10000;
        step();
        @(negedge clk);
        chk("irq_unmasked", 32'(flag_irq), 32'd1);

        // Clear coincident with accept keeps only the new flags
        step();
        drive(1'b0, 8'h20, 23'h1, 5'b10000);
        clear_sticky = 1'b1;
        step();
        in_valid     = 1'b0;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_pre_sticky", 32'(sticky_flags), 32'h10);
        step();
        drive(1'b0, 8'h7F, 23'h0, 5'b00010);
        clear_sticky = 1'b1;
        step();
        in_valid     = 1'b0;
        clear_sticky = 1'b0;
        @(negedge clk);
        chk("clr_acc_sticky", 32'(sticky_flags), 32'h02);
        chk("clr_irq_hold",   32'(flag_irq),     32'd1);
        step();
        @(negedge clk);
        chk("clr_irq_drop", 32'(flag_irq), 32'd0);
        step();

        // Back-pressure: three offers into a two-entry buffer with the output stalled
        out_ready = 1'b0;
        drive(1'b0, 8'h3F, 23'h1, 5'b0);
        step();
        drive(1'b0, 8'h3F, 23'h2, 5'b0);
        step();
        drive(1'b0, 8'h3F, 23'h3, 5'b0);
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_stall0",     out_result,    32'h1F800001);
        step();
        @(negedge clk);
        chk("bp_stall1",     out_result,    32'h1F800001);
        chk("bp_still_full", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_word1", out_result, 32'h1F800001);
        step();
        @(negedge clk);
        chk("bp_word2",  out_result,    32'h1F800002);
        chk("bp_ready2", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_word3", out_result, 32'h1F800003);
        step();
        @(negedge clk);
        chk("bp_empty", 32'(out_valid), 32'd0);
        chk("bp_hold",  out_result,     32'h1F800003);
        step();

        // Simultaneous accept and pop at occupancy one
        out_ready = 1'b0;
        drive(1'b0, 8'h40, 23'h100, 5'b0);
        step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h40, 23'(32'h101 + i), 5'b0);
            out_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("sim%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("sim%0d_ready", i), 32'(in_ready),  32'd1);
            chk($sformatf("sim%0d_word", i),  out_result,     32'h20000100 + 32'(i));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sim_last", out_result, 32'h2000010A);
        step();
        @(negedge clk);
        chk("sim_empty", 32'(out_valid), 32'd0);
        step();

        // Randomized traffic with a mid-operation reset
        for (int i = 0; i < 600; i++) begin
            logic [4:0] f;
            f = 5'($urandom) & 5'($urandom);
            drive(1'($urandom),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 5) == 0) ? 23'h0 : 23'($urandom), f);
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 2) != 0);
            clear_sticky = ($urandom_range(0, 7) == 0);
            if (i % 16 == 0) irq_mask = 5'($urandom);
            if (i == 300) begin
                #1;
                rst_n = 1'b0;
                step();
                step();
                rst_n = 1'b1;
            end
            step();
        end

        in_valid     = 1'b0;
        clear_sticky = 1'b0;
        out_ready    = 1'b1;
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
